grom_button_conditioner: RTL and testbench



---
 rtl/grom_pkg.sv | 19 +
 rtl/grom_sync_2ff.sv | 30 +++
 rtl/grom_button_conditioner.sv | 200 ++++++++++++++++++++
 tb/tb_grom_button_conditioner.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/grom_pkg.sv
// grom_pkg: shared types and default cycle constants for the grom8 button path.
// Holds the button-conditioner FSM state encoding and the default debounce,
// reset-hold and long-press cycle counts used by grom_top.
package grom_pkg;

  // Debounce FSM state encoding (2 bits)
  typedef enum logic [1:0] {
    BTN_RELEASED     = 2'd0,
    BTN_PRESS_WAIT   = 2'd1,
    BTN_PRESSED      = 2'd2,
    BTN_RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Default cycle counts at 25 MHz
  localparam int unsigned GROM_DEBOUNCE_CYCLES   = 250000;    // 10 ms
  localparam int unsigned GROM_RESET_HOLD_CYCLES = 16;
  localparam int unsigned GROM_LONG_PRESS_CYCLES = 25000000;  // 1 s

endpackage

// File: rtl/grom_sync_2ff.sv
// grom_sync_2ff: two-flop synchronizer for a single asynchronous input.
// Ports:
//   i_Clk   - destination clock
//   i_Rst_L - asynchronous active-low reset, clears both stages to 0
//   i_D     - asynchronous input
//   o_Q     - synchronized output (second stage)
module grom_sync_2ff (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_D,
  output logic o_Q
);

  logic meta_q;
  logic sync_q;

  // Two-stage shift; only the second stage leaves the module
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_D;
      sync_q <= meta_q;
    end
  end

  assign o_Q = sync_q;

endmodule

// File: rtl/grom_button_conditioner.sv
// grom_button_conditioner: synchronizes and debounces the board push-button
// and produces a stretched CPU reset plus single-cycle press/release pulses.
// Optional feature macro: GROM_LONG_PRESS_EN enables the o_Long_Press pulse;
// when undefined the long-press counter is absent and o_Long_Press is 0.
// Ports:
//   i_Clk        - system clock, rising edge
//   i_Rst_L      - asynchronous active-low reset
//   i_Switch     - raw button, 1 = pressed
//   o_Switch     - debounced button level
//   o_Press      - one-cycle pulse on accepted press
//   o_Release    - one-cycle pulse on accepted release
//   o_Cpu_Reset  - active-high reset for grom_computer
//   o_Long_Press - one-cycle pulse LONG_PRESS_CYCLES after o_Press
module grom_button_conditioner
  import grom_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = GROM_DEBOUNCE_CYCLES,
  parameter int unsigned RESET_HOLD_CYCLES = GROM_RESET_HOLD_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = GROM_LONG_PRESS_CYCLES
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Cpu_Reset,
  output logic o_Long_Press
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HBW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [DBW-1:0] DEB_MAX   = DBW'(DEBOUNCE_CYCLES);
  localparam logic [HBW-1:0] HOLD_INIT = HBW'(RESET_HOLD_CYCLES);

  // All cycle counts must be at least 1
  if (DEBOUNCE_CYCLES < 1 || RESET_HOLD_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_param_check
    $error("grom_button_conditioner: cycle parameters must be >= 1");
  end

  logic           sw_sync;
  btn_state_e     state_q,     state_d;
  logic [DBW-1:0] cnt_q,       cnt_d;
  logic [DBW-1:0] cnt_inc;
  logic [HBW-1:0] hold_q,      hold_d;
  logic           switch_q,    switch_d;
  logic           press_q,     press_d;
  logic           release_q,   release_d;
  logic           cpu_reset_q, cpu_reset_d;

  grom_sync_2ff u_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_D     (i_Switch),
    .o_Q     (sw_sync)
  );

  // State and output registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= BTN_RELEASED;
      cnt_q       <= '0;
      hold_q      <= HOLD_INIT;
      switch_q    <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      switch_q    <= switch_d;
      press_q     <= press_d;
      release_q   <= release_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  // Debounce FSM, hold counter and CPU reset next-state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    switch_d  = switch_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = hold_q;
    // Saturating increment; the counter never wraps
    cnt_inc   = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + DBW'(1);

    unique case (state_q)
      BTN_RELEASED: begin
        if (sw_sync) begin
          // A one-cycle debounce accepts on the very first sample
          if (DEB_MAX == DBW'(1)) begin
            state_d  = BTN_PRESSED;
            cnt_d    = '0;
            switch_d = 1'b1;
            press_d  = 1'b1;
          end else begin
            state_d  = BTN_PRESS_WAIT;
            cnt_d    = DBW'(1);
          end
        end
      end
      BTN_PRESS_WAIT: begin
        if (!sw_sync) begin
          state_d = BTN_RELEASED;
          cnt_d   = '0;
        end else if (cnt_inc == DEB_MAX) begin
          state_d  = BTN_PRESSED;
          cnt_d    = '0;
          switch_d = 1'b1;
          press_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      BTN_PRESSED: begin
        if (!sw_sync) begin
          if (DEB_MAX == DBW'(1)) begin
            state_d   = BTN_RELEASED;
            cnt_d     = '0;
            switch_d  = 1'b0;
            release_d = 1'b1;
          end else begin
            state_d   = BTN_RELEASE_WAIT;
            cnt_d     = DBW'(1);
          end
        end
      end
      BTN_RELEASE_WAIT: begin
        if (sw_sync) begin
          state_d = BTN_PRESSED;
          cnt_d   = '0;
        end else if (cnt_inc == DEB_MAX) begin
          state_d   = BTN_RELEASED;
          cnt_d     = '0;
          switch_d  = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = BTN_RELEASED;
        cnt_d   = '0;
      end
    endcase

    // Hold reloads on accepted release and drains only while released
    if (release_d) begin
      hold_d = HOLD_INIT;
    end else if (!switch_q && (hold_q != '0)) begin
      hold_d = hold_q - HBW'(1);
    end

    cpu_reset_d = switch_d || (hold_d != '0);
  end

  assign o_Switch    = switch_q;
  assign o_Press     = press_q;
  assign o_Release   = release_q;
  assign o_Cpu_Reset = cpu_reset_q;

`ifdef GROM_LONG_PRESS_EN
  localparam int unsigned LBW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [LBW-1:0] LP_MAX = LBW'(LONG_PRESS_CYCLES);

  logic [LBW-1:0] lp_cnt_q, lp_cnt_d;
  logic           long_q,   long_d;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      lp_cnt_q <= '0;
      long_q   <= 1'b0;
    end else begin
      lp_cnt_q <= lp_cnt_d;
      long_q   <= long_d;
    end
  end

  // Runs while the debounced level is pressed (including release bounce);
  // saturating at LP_MAX gives exactly one pulse per accepted press.
  always_comb begin
    lp_cnt_d = lp_cnt_q;
    long_d   = 1'b0;
    if (press_d) begin
      lp_cnt_d = '0;
    end else if (switch_q && (lp_cnt_q != LP_MAX)) begin
      lp_cnt_d = lp_cnt_q + LBW'(1);
      long_d   = (lp_cnt_d == LP_MAX);
    end
  end

  assign o_Long_Press = long_q;
`else
  assign o_Long_Press = 1'b0;
`endif

endmodule

// File: tb/tb_grom_button_conditioner.sv
// Testbench for grom_button_conditioner with DEBOUNCE=4, HOLD=3, LONG=10.
// The reference model works on the history of sampled button values: the
// debounced level flips once the last DEBOUNCE samples seen through the
// two-flop synchronizer all agree on the new level.
module tb_grom_button_conditioner;

  localparam int D = 4;
  localparam int H = 3;
  localparam int L = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic sw_in = 1'b0;
  logic o_sw, o_press, o_rel, o_rst, o_long;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic hist[$];
  logic exp_sw, exp_press, exp_rel, exp_long;
  int   rel_age;
  int   press_age;

  always #5 clk = ~clk;

  grom_button_conditioner #(
    .DEBOUNCE_CYCLES   (D),
    .RESET_HOLD_CYCLES (H),
    .LONG_PRESS_CYCLES (L)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Switch     (sw_in),
    .o_Switch     (o_sw),
    .o_Press      (o_press),
    .o_Release    (o_rel),
    .o_Cpu_Reset  (o_rst),
    .o_Long_Press (o_long)
  );

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(1'b0);
    exp_sw    = 1'b0;
    exp_press = 1'b0;
    exp_rel   = 1'b0;
    exp_long  = 1'b0;
    rel_age   = 0;
    press_age = L + 1;
  endtask

  // One rising edge of the model; s is the button value sampled at that edge
  task automatic model_edge(input logic s);
    logic prev_sw, all_same, v;
    hist.push_back(s);
    if (hist.size() > D + 2) void'(hist.pop_front());
    // hist[0..D-1] are the samples taken 2..D+1 edges ago
    v = hist[0];
    all_same = 1'b1;
    for (int i = 1; i < D; i++) if (hist[i] !== v) all_same = 1'b0;
    prev_sw   = exp_sw;
    exp_press = 1'b0;
    exp_rel   = 1'b0;
    exp_long  = 1'b0;
    if (prev_sw) begin
      if (press_age <= L) press_age++;
      exp_long = (press_age == L);
    end
    if (all_same && (v !== prev_sw)) begin
      exp_sw = v;
      if (v) begin
        exp_press = 1'b1;
        press_age = 0;
      end else begin
        exp_rel = 1'b1;
      end
    end
    if (exp_rel) rel_age = 0;
    else if (rel_age < 1000) rel_age++;
`ifndef GROM_LONG_PRESS_EN
    exp_long = 1'b0;
`endif
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".switch"},  o_sw,    exp_sw);
    chk({ph, ".press"},   o_press, exp_press);
    chk({ph, ".release"}, o_rel,   exp_rel);
    chk({ph, ".cpu_rst"}, o_rst,   exp_sw || (rel_age < H));
    chk({ph, ".long"},    o_long,  exp_long);
  endtask

  // Drive s for one cycle starting at a falling edge, check at the next one
  task automatic tick(input logic s, input string ph);
    sw_in = s;
    @(posedge clk);
    if (rst_n) model_edge(s);
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic hold(input logic s, input int n, input string ph);
    for (int i = 0; i < n; i++) tick(s, ph);
  endtask

  // Asynchronous reset pulse from a falling-edge boundary
  task automatic pulse_reset(input logic s, input string ph);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all({ph, ".async"});
    @(negedge clk);
    hold(s, 2, {ph, ".inrst"});
    rst_n = 1'b1;
  endtask

  initial begin
    int len;
    logic lvl;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset stretch after deassert, button released
    hold(1'b0, 6, "por");
    // Clean press, then clean release
    hold(1'b1, 12, "press");
    hold(1'b0, 12, "release");
    // Bouncing press 1,0,1,0 then steady
    tick(1'b1, "bnc"); tick(1'b0, "bnc"); tick(1'b1, "bnc"); tick(1'b0, "bnc");
    hold(1'b1, 10, "bnc_steady");
    // Short release bounce while pressed, then real release
    tick(1'b0, "rbnc"); tick(1'b0, "rbnc"); tick(1'b1, "rbnc");
    hold(1'b1, 4, "rbnc");
    hold(1'b0, 10, "rbnc_rel");
    // Long hold
    hold(1'b1, 30, "long");
    hold(1'b0, 10, "long_rel");
    // Re-press during the reset hold window
    hold(1'b1, 8, "repress");
    hold(1'b0, 6, "repress");
    hold(1'b1, 8, "repress");
    hold(1'b0, 12, "repress");
    // Reset while the press is still being debounced, button held
    hold(1'b1, 3, "rst_pw");
    pulse_reset(1'b1, "rst_pw");
    hold(1'b1, 12, "rst_pw_after");
    hold(1'b0, 12, "rst_pw_rel");

    // Randomized segments, mostly bounce-length with some long holds
    for (int seg = 0; seg < 250; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 25))
                                        : int'($urandom_range(1, 5));
      hold(lvl, len, "rand");
      if ($urandom_range(0, 59) == 0) pulse_reset(lvl, "rand_rst");
    end
    hold(1'b0, 12, "tail");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
